// File: rtl/sopc_lcd_bus_pio_if.sv
// Register-bus port bundle for the LCD bus PIO: register select, write strobe and data,
// plus the registered read-data return path.
interface sopc_lcd_bus_pio_if;
  // Handshake: there is no valid/ready pair. A write is accepted on every rising edge where
  // chipselect=1 and write_n=0. readdata always reflects the address of the previous cycle.
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sopc_lcd_bus_pio.sv
// Register-mapped parallel LCD bus master: idle PIO on a tristate bus, plus timed
// setup/pulse/hold read or write cycles with active-low strobes.
module sopc_lcd_bus_pio #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  sopc_lcd_bus_pio_if.slave bus,
  inout  wire  [DATA_W-1:0] bidir_port,
  output logic              lcd_cs_n,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic              lcd_rs,
  output logic              irq,
  output logic [1:0]        o_dbg_state,
  output logic [DATA_W-1:0] o_dbg_bus_oe
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_TIMING  = 3'd2;
  localparam logic [2:0] A_CMD     = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;
  localparam logic [2:0] A_CAPTURE = 3'd5;
  localparam logic [2:0] A_IRQ_EN  = 3'd6;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [DATA_W-1:0]   r_data_out;
  logic [DATA_W-1:0]   r_dir;
  logic [DATA_W-1:0]   r_capture;
  logic [DATA_W-1:0]   r_bus_out;
  logic [DATA_W-1:0]   r_bus_oe;
  logic [3*CNT_W-1:0]  r_timing;
  logic                r_is_read;
  logic                r_rs;
  logic                r_done;
  logic                r_overrun;
  logic                r_irq_en;
  logic                r_irq;
  logic                r_cs_n;
  logic                r_wr_n;
  logic                r_rd_n;
  logic [31:0]         r_readdata;

  logic [CNT_W-1:0]    w_setup;
  logic [CNT_W-1:0]    w_pulse;
  logic [CNT_W-1:0]    w_hold;
  logic                w_wr;
  logic                w_busy;
  logic                w_wr_data;
  logic                w_wr_dir;
  logic                w_wr_timing;
  logic                w_wr_cmd;
  logic                w_wr_status;
  logic                w_wr_irq_en;
  logic                w_cmd_accept;
  logic                w_blocked;
  logic                w_hold_done;
  logic                w_last_pulse;
  logic [DATA_W-1:0]   w_data_out_nxt;
  logic [DATA_W-1:0]   w_dir_nxt;
  logic [3*CNT_W-1:0]  w_timing_nxt;
  logic                w_is_read_nxt;
  logic                w_rs_nxt;
  logic                w_done_nxt;
  logic                w_overrun_nxt;
  logic                w_irq_en_nxt;
  logic [DATA_W-1:0]   w_bus_oe_nxt;
  logic [31:0]         w_readdata_nxt;
  logic                w_unused_wdata;

  assign w_setup = r_timing[CNT_W-1:0];
  assign w_pulse = r_timing[2*CNT_W-1:CNT_W];
  assign w_hold  = r_timing[3*CNT_W-1:2*CNT_W];

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_data   = w_wr && (bus.address == A_DATA);
  assign w_wr_dir    = w_wr && (bus.address == A_DIR);
  assign w_wr_timing = w_wr && (bus.address == A_TIMING);
  assign w_wr_cmd    = w_wr && (bus.address == A_CMD);
  assign w_wr_status = w_wr && (bus.address == A_STATUS);
  assign w_wr_irq_en = w_wr && (bus.address == A_IRQ_EN);

  // A CMD on the HOLD->IDLE edge still sees busy, so it is rejected as an overrun.
  assign w_cmd_accept = w_wr_cmd & ~w_busy;
  assign w_blocked    = w_busy & (w_wr_cmd | w_wr_data | w_wr_timing);
  assign w_hold_done  = (r_state == S_HOLD)  && (r_cnt == '0);
  assign w_last_pulse = (r_state == S_PULSE) && (r_cnt == '0);

  assign w_unused_wdata = ^bus.writedata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = w_setup;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = w_pulse;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = w_hold;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Next register values feed both the registers and the registered pin drivers,
  // so pins change on the same edge as the state they depend on.
  always_comb begin
    w_data_out_nxt = r_data_out;
    w_dir_nxt      = r_dir;
    w_timing_nxt   = r_timing;
    w_is_read_nxt  = r_is_read;
    w_rs_nxt       = r_rs;
    w_irq_en_nxt   = r_irq_en;
    if (w_wr_data && !w_busy)   w_data_out_nxt = bus.writedata[DATA_W-1:0];
    if (w_wr_dir)               w_dir_nxt      = bus.writedata[DATA_W-1:0];
    if (w_wr_timing && !w_busy) w_timing_nxt   = bus.writedata[3*CNT_W-1:0];
    if (w_wr_irq_en)            w_irq_en_nxt   = bus.writedata[0];
    if (w_cmd_accept) begin
      w_is_read_nxt = bus.writedata[0];
      w_rs_nxt      = bus.writedata[1];
    end
    w_done_nxt    = w_hold_done | (r_done & ~(w_wr_status & bus.writedata[1]));
    w_overrun_nxt = w_blocked | (r_overrun & ~(w_wr_status & bus.writedata[2]));

    w_bus_oe_nxt = '0;
    if (w_state_nxt == S_IDLE)  w_bus_oe_nxt = w_dir_nxt;
    else if (!w_is_read_nxt)    w_bus_oe_nxt = '1;
  end

  always_comb begin
    w_readdata_nxt = '0;
    case (bus.address)
      A_DATA:    w_readdata_nxt = 32'(bidir_port);
      A_DIR:     w_readdata_nxt = 32'(r_dir);
      A_TIMING:  w_readdata_nxt = 32'(r_timing);
      A_CMD:     w_readdata_nxt = 32'({r_rs, r_is_read});
      A_STATUS:  w_readdata_nxt = 32'({r_overrun, r_done, w_busy});
      A_CAPTURE: w_readdata_nxt = 32'(r_capture);
      A_IRQ_EN:  w_readdata_nxt = 32'(r_irq_en);
      default:   w_readdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_dir      <= '0;
      r_timing   <= '0;
      r_capture  <= '0;
      r_is_read  <= 1'b0;
      r_rs       <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_bus_out  <= '0;
      r_bus_oe   <= '0;
      r_readdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data_out <= w_data_out_nxt;
      r_dir      <= w_dir_nxt;
      r_timing   <= w_timing_nxt;
      r_is_read  <= w_is_read_nxt;
      r_rs       <= w_rs_nxt;
      r_done     <= w_done_nxt;
      r_overrun  <= w_overrun_nxt;
      r_irq_en   <= w_irq_en_nxt;
      r_irq      <= w_done_nxt & w_irq_en_nxt;
      r_cs_n     <= (w_state_nxt == S_IDLE);
      r_wr_n     <= !((w_state_nxt == S_PULSE) && !w_is_read_nxt);
      r_rd_n     <= !((w_state_nxt == S_PULSE) && w_is_read_nxt);
      r_bus_out  <= w_data_out_nxt;
      r_bus_oe   <= w_bus_oe_nxt;
      r_readdata <= w_readdata_nxt;
      if (w_last_pulse && r_is_read) r_capture <= bidir_port;
    end
  end

  for (genvar g = 0; g < DATA_W; g++) begin : g_bus
    assign bidir_port[g] = r_bus_oe[g] ? r_bus_out[g] : 1'bz;
  end

  assign bus.readdata  = r_readdata;
  assign lcd_cs_n      = r_cs_n;
  assign lcd_wr_n      = r_wr_n;
  assign lcd_rd_n      = r_rd_n;
  assign lcd_rs        = r_rs;
  assign irq           = r_irq;
  assign o_dbg_state   = r_state;
  assign o_dbg_bus_oe  = r_bus_oe;

endmodule

// File: tb/tb_sopc_lcd_bus_pio.sv
// Directed bench for sopc_lcd_bus_pio: drivers push expected pin/register values with a
// due cycle into exp_q; a negedge monitor compares each entry when its cycle arrives.
module tb_sopc_lcd_bus_pio;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_TIMING  = 3'd2;
  localparam logic [2:0] A_CMD     = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;
  localparam logic [2:0] A_CAPTURE = 3'd5;
  localparam logic [2:0] A_IRQ_EN  = 3'd6;
  localparam logic [2:0] A_NONE    = 3'd7;

  localparam int K_RDATA = 0;
  localparam int K_CS    = 1;
  localparam int K_WR    = 2;
  localparam int K_RDN   = 3;
  localparam int K_RS    = 4;
  localparam int K_IRQ   = 5;
  localparam int K_OE    = 6;
  localparam int K_BUS   = 7;
  localparam int K_ST    = 8;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic              clk;
  logic              reset;
  wire  [DATA_W-1:0] bidir_port;
  logic              lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, irq;
  logic [1:0]        o_dbg_state;
  logic [DATA_W-1:0] o_dbg_bus_oe;
  logic [DATA_W-1:0] tb_oe;
  logic [DATA_W-1:0] tb_val;

  chk_t        exp_q[$];
  int          cyc = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [31:0] mon_act;

  sopc_lcd_bus_pio_if bus_if ();

  sopc_lcd_bus_pio #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.slave),
    .bidir_port   (bidir_port),
    .lcd_cs_n     (lcd_cs_n),
    .lcd_wr_n     (lcd_wr_n),
    .lcd_rd_n     (lcd_rd_n),
    .lcd_rs       (lcd_rs),
    .irq          (irq),
    .o_dbg_state  (o_dbg_state),
    .o_dbg_bus_oe (o_dbg_bus_oe)
  );

  // External LCD device model: drives only the bits selected by tb_oe.
  for (genvar g = 0; g < DATA_W; g++) begin : g_ext
    assign bidir_port[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(int kind);
    case (kind)
      K_RDATA: return bus_if.readdata;
      K_CS:    return 32'(lcd_cs_n);
      K_WR:    return 32'(lcd_wr_n);
      K_RDN:   return 32'(lcd_rd_n);
      K_RS:    return 32'(lcd_rs);
      K_IRQ:   return 32'(irq);
      K_OE:    return 32'(o_dbg_bus_oe);
      K_BUS:   return 32'(bidir_port);
      K_ST:    return 32'(o_dbg_state);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        mon_act = probe(exp_q[i].kind);
        n_compared++;
        if (mon_act !== exp_q[i].exp) begin
          n_mismatched++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                   exp_q[i].name, mon_act, exp_q[i].exp, cyc);
        end
        exp_q.delete(i);
      end
    end
  end

  // Driver tasks: each starts and ends just after a rising edge.
  task automatic expect_at(input int d, input int kind, input logic [31:0] v, input string name);
    chk_t c;
    c.due  = cyc + d;
    c.kind = kind;
    c.exp  = v;
    c.name = name;
    exp_q.push_back(c);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] v, input string name);
    bus_if.address = a;
    expect_at(1, K_RDATA, v, name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tb_oe             = '0;
    tb_val            = '0;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    reset             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    expect_at(0, K_CS, 1, "rst_cs_n");
    expect_at(0, K_WR, 1, "rst_wr_n");
    expect_at(0, K_RDN, 1, "rst_rd_n");
    expect_at(0, K_RS, 0, "rst_rs");
    expect_at(0, K_IRQ, 0, "rst_irq");
    expect_at(0, K_OE, 0, "rst_bus_oe");
    expect_at(0, K_ST, 0, "rst_state");
    expect_at(0, K_RDATA, 0, "rst_readdata");
    bus_read(A_STATUS, 0, "rst_status");
    bus_read(A_TIMING, 0, "rst_timing");
    bus_read(A_DIR, 0, "rst_dir");
    bus_read(A_CAPTURE, 0, "rst_capture");
    bus_read(A_IRQ_EN, 0, "rst_irq_en");

    // Timed write: setup=1, pulse=3, hold=2 -> 2+4+3 cycles of cs_n low
    bus_write(A_TIMING, 32'h0002_0301);
    bus_write(A_DATA, 32'h0000_A55A);
    bus_write(A_CMD, 32'h2);
    for (int d = 0; d <= 9; d++) expect_at(d, K_CS, (d <= 8) ? 0 : 1, "wr_cs_n");
    for (int d = 1; d <= 6; d++) expect_at(d, K_WR, (d >= 2 && d <= 5) ? 0 : 1, "wr_wr_n");
    for (int d = 0; d <= 8; d += 4) begin
      expect_at(d, K_OE, 32'hFFFF, "wr_bus_oe");
      expect_at(d, K_BUS, 32'hA55A, "wr_bus");
    end
    expect_at(3, K_RDN, 1, "wr_rd_n");
    expect_at(0, K_RS, 1, "wr_rs");
    expect_at(9, K_ST, 0, "wr_end_state");
    wait_cycles(9);
    bus_read(A_STATUS, 32'h2, "wr_status_done");

    // Interrupt raise and clear
    bus_write(A_IRQ_EN, 32'h1);
    expect_at(0, K_IRQ, 1, "irq_set");
    bus_write(A_STATUS, 32'h2);
    expect_at(0, K_IRQ, 0, "irq_clr");
    bus_read(A_STATUS, 0, "irq_status_clr");

    // Timed read with zero timing: 3 cycles cs_n, 1 cycle rd_n
    tb_val = 16'h1234;
    tb_oe  = 16'hFFFF;
    bus_write(A_TIMING, 32'h0);
    bus_write(A_CMD, 32'h1);
    for (int d = 0; d <= 3; d++) expect_at(d, K_CS, (d <= 2) ? 0 : 1, "rd_cs_n");
    for (int d = 0; d <= 2; d++) begin
      expect_at(d, K_RDN, (d == 1) ? 0 : 1, "rd_rd_n");
      expect_at(d, K_OE, 0, "rd_bus_oe");
    end
    expect_at(1, K_WR, 1, "rd_wr_n");
    expect_at(0, K_RS, 0, "rd_rs");
    wait_cycles(3);
    bus_read(A_CAPTURE, 32'h1234, "rd_capture");
    bus_read(A_STATUS, 32'h2, "rd_status");
    tb_oe = '0;
    bus_write(A_STATUS, 32'h2);

    // Back-to-back: CMD on HOLD->IDLE edge is an overrun, next-cycle CMD is accepted
    bus_write(A_CMD, 32'h0);
    wait_cycles(2);
    bus_write(A_CMD, 32'h2);
    expect_at(0, K_ST, 0, "b2b_rejected_state");
    expect_at(0, K_CS, 1, "b2b_rejected_cs_n");
    bus_write(A_CMD, 32'h2);
    expect_at(0, K_ST, 1, "b2b_accepted_state");
    expect_at(0, K_CS, 0, "b2b_accepted_cs_n");
    expect_at(0, K_RS, 1, "b2b_rs");
    wait_cycles(3);
    bus_read(A_STATUS, 32'h6, "b2b_status");
    bus_write(A_STATUS, 32'h6);
    bus_read(A_STATUS, 0, "b2b_status_clr");

    // Done set and clear on the same edge: set wins
    bus_write(A_CMD, 32'h0);
    wait_cycles(2);
    bus_write(A_STATUS, 32'h6);
    bus_read(A_STATUS, 32'h2, "set_wins_status");
    bus_write(A_STATUS, 32'h2);

    // Writes while busy are ignored and flag overrun
    bus_write(A_TIMING, 32'h0002_0301);
    bus_write(A_CMD, 32'h2);
    for (int d = 2; d <= 5; d++) expect_at(d, K_WR, 0, "busy_wr_n");
    expect_at(3, K_RDN, 1, "busy_rd_n");
    expect_at(3, K_RS, 1, "busy_rs");
    expect_at(4, K_BUS, 32'hA55A, "busy_bus");
    expect_at(9, K_CS, 1, "busy_end_cs_n");
    bus_write(A_CMD, 32'h1);
    bus_write(A_DATA, 32'hFFFF);
    bus_read(A_STATUS, 32'h5, "busy_status");
    wait_cycles(6);
    bus_read(A_STATUS, 32'h6, "busy_status_done");
    bus_write(A_DIR, 32'hFFFF);
    expect_at(1, K_BUS, 32'hA55A, "busy_data_bus");
    bus_read(A_DATA, 32'hA55A, "busy_data_kept");
    bus_write(A_STATUS, 32'h6);
    bus_read(A_TIMING, 32'h0002_0301, "busy_timing_kept");

    // Idle PIO with split direction
    bus_write(A_DIR, 32'h00FF);
    bus_write(A_DATA, 32'hBEEF);
    expect_at(0, K_OE, 32'h00FF, "pio_bus_oe");
    tb_val = 16'h1200;
    tb_oe  = 16'hFF00;
    wait_cycles(1);
    expect_at(1, K_BUS, 32'h12EF, "pio_bus");
    bus_read(A_DATA, 32'h12EF, "pio_data_read");
    bus_read(A_DIR, 32'h00FF, "pio_dir_read");
    tb_oe = '0;
    bus_write(A_DIR, 32'h0);

    // Unmapped address and command readback
    bus_write(A_NONE, 32'hFFFF_FFFF);
    bus_read(A_NONE, 0, "addr7_read");
    bus_read(A_CMD, 32'h2, "cmd_read");

    // Reset during PULSE aborts the transaction
    bus_write(A_TIMING, 32'h0000_0500);
    bus_write(A_CMD, 32'h0);
    expect_at(1, K_WR, 0, "abort_pre_wr_n");
    wait_cycles(1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_at(0, K_CS, 1, "abort_cs_n");
    expect_at(0, K_WR, 1, "abort_wr_n");
    expect_at(0, K_OE, 0, "abort_bus_oe");
    expect_at(0, K_ST, 0, "abort_state");
    expect_at(0, K_RDATA, 0, "abort_readdata");
    bus_read(A_STATUS, 0, "abort_status");
    bus_read(A_TIMING, 0, "abort_timing");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_cycles(1);
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: got %0d pending checks expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sopc_lcd_bus_pio.md
SOPC_LCD_BUS_PIO -- requirements
Module: sopc_lcd_bus_pio

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bus width, legal 8..32.
REQ-002 SHALL have parameter CNT_W, default 8: width of each timing field, legal 1..10.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port address, input, 3: register select.
REQ-006 SHALL have ports chipselect and write_n, inputs, 1 each: write strobe is chipselect & ~write_n.
REQ-007 SHALL have port writedata, input, 32: write data.
REQ-008 SHALL have port readdata, output, 32: registered read data; bits above a register's width read 0.
REQ-009 SHALL have port bidir_port, inout, DATA_W: LCD data bus.
REQ-010 SHALL have ports lcd_cs_n, lcd_wr_n and lcd_rd_n, outputs, 1 each: active-low LCD strobes.
REQ-011 SHALL have port lcd_rs, output, 1: register/data select.
REQ-012 SHALL have port irq, output, 1: level interrupt.

Function
REQ-013 Register map: 0 DATA, 1 DIR, 2 TIMING, 3 CMD, 4 STATUS, 5 CAPTURE, 6 IRQ_EN, 7 reads 0; writes to 7 ignored.
REQ-014 readdata SHALL update every cycle from the address presented (1-cycle latency, no read strobe): DATA returns live bidir_port; all others return register contents.
REQ-015 DATA write loads data_out[DATA_W-1:0]; DIR write loads per-bit output enable.
REQ-016 TIMING fields: setup [CNT_W-1:0], pulse [2*CNT_W-1:CNT_W], hold [3*CNT_W-1:2*CNT_W]; a phase with value N lasts N+1 cycles.
REQ-017 FSM states: IDLE, SETUP, PULSE, HOLD; IDLE->SETUP on CMD write; each phase advances when its down-counter reaches 0; HOLD->IDLE.
REQ-018 CMD write in IDLE latches bit0 (0 = write, 1 = read) and bit1 (rs), then enters SETUP next cycle.
REQ-019 Idle bus: bit i driven with data_out[i] when DIR[i]=1, else Z.
REQ-020 Write transaction: all bits driven with data_out in SETUP, PULSE and HOLD, regardless of DIR.
REQ-021 Read transaction: all bits Z in SETUP, PULSE and HOLD, regardless of DIR.
REQ-022 lcd_cs_n SHALL be 0 in SETUP, PULSE and HOLD.
REQ-023 In PULSE, lcd_wr_n = 0 (write transaction) or lcd_rd_n = 0 (read transaction); both strobes are 1 otherwise.
REQ-024 lcd_rs SHALL hold the latched rs from SETUP entry until the next CMD is accepted.
REQ-025 Outputs are registered; no strobe glitches.
REQ-026 Read transaction: CAPTURE SHALL load bidir_port on the last PULSE cycle.
REQ-027 STATUS bit0 busy (state != IDLE); bit1 done, sticky, set on HOLD->IDLE; bit2 overrun, sticky.
REQ-028 Writing 1 to STATUS bit1 or bit2 clears it; if set and clear coincide, set wins.
REQ-029 While busy, writes to CMD, DATA and TIMING are ignored and set overrun; DIR and IRQ_EN writes are accepted.
REQ-030 irq = done & IRQ_EN[0], registered.
REQ-031 Back-to-back: a CMD write in the same cycle as HOLD->IDLE is treated as busy (overrun); a CMD write in the following cycle is accepted.

Reset
REQ-032 On reset: state IDLE; data_out, DIR, TIMING, CAPTURE, IRQ_EN, STATUS and readdata all 0.
REQ-033 On reset: lcd_cs_n = lcd_wr_n = lcd_rd_n = 1, lcd_rs = 0, irq = 0, bus all Z.
REQ-034 Reset mid-transaction aborts on that edge; strobes return to 1 and done is not set.

Verification
REQ-035 TIMING=0x020301, DATA=0xA55A, CMD=0x2 -> cs_n low 2+4+3 = 9 cycles; wr_n low 4 cycles starting cycle 3; bus 0xA55A throughout; rs=1; done=1.
REQ-036 External bus drives 0x1234, TIMING=0, CMD=0x1 -> rd_n low 1 cycle, bus Z, CAPTURE reads 0x1234, cs_n low 3 cycles.
REQ-037 IRQ_EN=1, completed transaction -> irq=1; write STATUS=0x2 -> irq=0 the cycle after the write.
REQ-038 CMD write while busy, and DATA=0xFFFF while busy -> transaction unaffected, DATA unchanged, STATUS=0x5 until done.
REQ-039 DIR=0x00FF, DATA=0xBEEF, idle -> bus low byte 0xEF driven, high byte Z; DATA readback shows external high byte.
REQ-040 reset asserted in PULSE with pulse=5 -> next edge cs_n = wr_n = 1, STATUS=0, bus Z.
